// File: rtl/lfsr_arbiter_if.sv
// Bundles the seed/request/grant signals of lfsr_arbiter. The testbench drives
// the master side, and the arbiter sits on the slave side.
interface lfsr_arbiter_if #(
  parameter int WIDTH = 10
);
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic [7:0]       lockup_cnt;

  modport master (
    output seed_load, seed, req,
    input  gnt, data, busy, lockup_cnt
  );

  modport slave (
    input  seed_load, seed, req,
    output gnt, data, busy, lockup_cnt
  );
endinterface

// File: rtl/lfsr_arbiter.sv
// Two-requester round-robin arbiter. It hands out words from an XNOR LFSR,
// and the LFSR advances WIDTH steps for each request it serves.
module lfsr_arbiter #(
  parameter int WIDTH = 10,
  parameter int X1    = 6,
  parameter int X2    = 9
) (
  input logic           clk,
  input logic           reset_n,
  lfsr_arbiter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DELIVER} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [7:0]       lockup_q, lockup_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] shifted;
  logic [7:0]       lockup_inc;

  // All ones is the XNOR LFSR's stuck state. It is cleared to zero instead of being shifted.
  assign shifted    = {q_q[WIDTH-2:0], ~(q_q[X1] ^ q_q[X2])};
  assign lockup_inc = (lockup_q == 8'hFF) ? lockup_q : lockup_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    data_d   = data_q;
    gnt_d    = 2'b00;
    lockup_d = lockup_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          state_d = LOAD;
        end else if (|bus.req) begin
          owner_d = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      LOAD: begin
        if (&bus.seed) begin
          q_d      = '0;
          lockup_d = lockup_inc;
        end else begin
          q_d = bus.seed;
        end
        state_d = IDLE;
      end
      SHIFT: begin
        if (&q_q) begin
          q_d      = '0;
          lockup_d = lockup_inc;
        end else begin
          q_d   = shifted;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (bus.req[owner_q]) begin
          gnt_d  = owner_q ? 2'b10 : 2'b01;
          data_d = q_q;
          last_d = owner_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // After reset the pointer says requester 1 was served last, so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      q_q      <= '0;
      data_q   <= '0;
      gnt_q    <= 2'b00;
      busy_q   <= 1'b0;
      lockup_q <= 8'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      data_q   <= data_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      lockup_q <= lockup_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.data       = data_q;
  assign bus.busy       = busy_q;
  assign bus.lockup_cnt = lockup_q;

endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter WIDTH, default 10: LFSR and data word width.
REQ-002 Parameter X1, default 6: first feedback tap index.
REQ-003 Parameter X2, default 9: second feedback tap index; X1 < X2 < WIDTH.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 seed_load  input  1  request to load seed into the LFSR.
REQ-007 seed  input  WIDTH  seed value, sampled when the load is accepted.
REQ-008 req  input  2  per-requester random-word request, level, held until gnt.
REQ-009 gnt  output  2  one-hot, one-cycle grant; data valid while gnt high.
REQ-010 data  output  WIDTH  last delivered random word, registered.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 lockup_cnt  output  8  saturating count of all-ones lockups cleared.

Function
REQ-013 The internal LFSR q SHALL shift as q[i+1] <= q[i] and q[0] <= ~(q[X1] ^ q[X2]).
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT and DELIVER.
REQ-015 In IDLE, seed_load SHALL take priority over req: seed_load=1 goes to LOAD; otherwise any req bit goes to SHIFT with owner latched and shift count cleared.
REQ-016 Owner selection SHALL be round-robin: on a tie, the requester not granted last wins; after reset, req[0] wins the first tie.
REQ-017 LOAD SHALL last one cycle: q <= seed, then IDLE; a seed of all ones SHALL load 0 instead and increment lockup_cnt.
REQ-018 SHIFT SHALL perform exactly WIDTH shifts, one per cycle, then go to DELIVER.
REQ-019 If q is all ones at a SHIFT edge, the block SHALL load q <= 0 instead of shifting, increment lockup_cnt, and not advance the shift count.
REQ-020 In DELIVER, if req[owner]=1 the block SHALL assert gnt[owner] for one cycle, present data <= q, and record owner as last granted.
REQ-021 If req[owner] is low in DELIVER, the block SHALL keep gnt at 0, leave data unchanged, and leave the round-robin pointer unchanged.
REQ-022 DELIVER SHALL always return to IDLE; back-to-back grants are separated by at least one IDLE cycle.
REQ-023 Latency: with req sampled in IDLE at edge n and no lockup, gnt SHALL be high in the cycle following edge n+WIDTH+1.
REQ-024 seed_load while busy SHALL be ignored; it takes effect only if still high in IDLE.
REQ-025 lockup_cnt SHALL saturate at 255.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 While reset_n=0, asynchronously: state=IDLE, q=0, data=0, gnt=0, busy=0, lockup_cnt=0, round-robin pointer favours req[0].
REQ-028 Reset asserted mid-SHIFT or mid-DELIVER SHALL abort the transaction with no gnt issued.

Verification
REQ-029 Reset, then req=2'b01 held (WIDTH=10): gnt=2'b01 for one cycle, 12 cycles after the request edge; data=10'h3F8.
REQ-030 req=2'b11 held continuously: gnt alternates 01, 10, 01, 10, and is never 2'b11.
REQ-031 seed_load=1 with seed=10'h3FF: q=0, lockup_cnt=1; seed_load=1 with seed=10'h001: q=10'h001 after one cycle.
REQ-032 seed_load and req[1] raised in the same IDLE cycle: LOAD first, then SHIFT for requester 1; seed_load raised during SHIFT: ignored until IDLE.
REQ-033 req[0] dropped mid-SHIFT: no gnt, data unchanged, and the next tie is still won by req[0].
REQ-034 reset_n pulsed low during SHIFT: all outputs return to reset values at once, and no gnt follows.
